// File: rtl/flop_delay_line.sv
// rtl/flop_delay_line.sv - programmable-latency flop pipeline with valid/clamp status
// Circular history of MAX_DELAY-1 samples feeds a registered output tap.
module flop_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DELAY  = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           num_clks,
  input  logic [DATA_WIDTH-1:0] flop_in,
  output logic [DATA_WIDTH-1:0] flop_out,
  output logic                  out_valid,
  output logic                  clamped
);

  localparam int DEPTH = MAX_DELAY - 1;
  localparam int CW    = $clog2(MAX_DELAY + 1);

  logic [DATA_WIDTH-1:0] hist [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  wptr_next;
  logic [PTR_WIDTH-1:0]  tap;
  logic [CW-1:0]         fill;
  logic [CW-1:0]         fill_next;
  logic [CW-1:0]         delay;
  logic                  delay_clamped;
  int                    tap_calc;

  // Full 32-bit compare so large requests never alias onto small delays.
  always_comb begin
    delay_clamped = 1'b0;
    delay         = CW'(num_clks);
    if (num_clks == 32'd0) begin
      delay         = CW'(1);
      delay_clamped = 1'b1;
    end else if (num_clks > 32'(MAX_DELAY)) begin
      delay         = CW'(MAX_DELAY);
      delay_clamped = 1'b1;
    end
  end

  // Slot wptr-j holds the sample from j edges ago; j = delay-1 may equal DEPTH,
  // which reads the oldest slot just before it is overwritten.
  always_comb begin
    tap_calc = int'(wptr) - (int'(delay) - 1);
    if (tap_calc < 0) begin
      tap_calc = tap_calc + DEPTH;
    end
    tap = PTR_WIDTH'(tap_calc);
  end

  always_comb begin
    wptr_next = (wptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wptr + PTR_WIDTH'(1);
    fill_next = (fill == CW'(MAX_DELAY)) ? fill : fill + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flop_out  <= '0;
      out_valid <= 1'b0;
      clamped   <= 1'b0;
      fill      <= '0;
      wptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else begin
      hist[wptr] <= flop_in;
      wptr       <= wptr_next;
      fill       <= fill_next;
      clamped    <= delay_clamped;
      out_valid  <= (fill_next >= delay);
      if (delay == CW'(1)) begin
        flop_out <= flop_in;
      end else begin
        flop_out <= hist[tap];
      end
    end
  end

endmodule

// File: tb/tb_flop_delay_line.sv
// tb/tb_flop_delay_line.sv - randomized self-checking bench for flop_delay_line
// Reference keeps every sample since reset and indexes it directly by delay.
module tb_flop_delay_line;

  logic        clk;
  logic        reset_n;
  logic [31:0] num_clks;
  logic [31:0] flop_in;
  logic [31:0] flop_out;
  logic        out_valid;
  logic        clamped;

  int checks;
  int errors;

  logic [31:0] samples[$];
  logic [31:0] exp_out;
  logic        exp_valid;
  logic        exp_clamped;

  flop_delay_line #(
    .DATA_WIDTH(32),
    .MAX_DELAY (16),
    .PTR_WIDTH (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .num_clks (num_clks),
    .flop_in  (flop_in),
    .flop_out (flop_out),
    .out_valid(out_valid),
    .clamped  (clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic rn, input logic [31:0] nc, input logic [31:0] din);
    int d;
    int n;
    int fill;
    if (!rn) begin
      samples.delete();
      exp_out     = '0;
      exp_valid   = 1'b0;
      exp_clamped = 1'b0;
    end else begin
      exp_clamped = 1'b0;
      if (nc == 0) begin
        d = 1;
        exp_clamped = 1'b1;
      end else if (nc > 16) begin
        d = 16;
        exp_clamped = 1'b1;
      end else begin
        d = int'(nc);
      end
      samples.push_back(din);
      n = samples.size();
      fill = (n > 16) ? 16 : n;
      exp_valid = (fill >= d);
      exp_out = (n >= d) ? samples[n - d] : 32'd0;
    end
  endtask

  task automatic step(input logic rn, input logic [31:0] nc, input logic [31:0] din);
    @(negedge clk);
    reset_n  = rn;
    num_clks = nc;
    flop_in  = din;
    @(posedge clk);
    model_edge(rn, nc, din);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 32'd1, 32'hDEAD_BEEF);
    step(1'b0, 32'd1, 32'hDEAD_BEEF);
    checks++;
    if (flop_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_out got=%h want=%h", flop_out, 32'd0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    checks++;
    if (clamped !== 1'b0) begin
      errors++;
      $display("FAIL reset_clamped got=%b want=0", clamped);
    end
  endtask

  task automatic test_pass_through();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'd1, 32'(i));
      checks++;
      if (flop_out !== 32'(i) || out_valid !== 1'b1 || clamped !== 1'b0) begin
        errors++;
        $display("FAIL pass_through edge=%0d got=%h/%b/%b want=%h/1/0", i, flop_out, out_valid, clamped, i);
      end
    end
  endtask

  task automatic test_delay5_wrap();
    logic [31:0] want;
    step(1'b0, 32'd5, 32'd0);
    for (int n = 0; n < 40; n++) begin
      step(1'b1, 32'd5, 32'hA000_0000 + 32'(n));
      want = (n >= 4) ? 32'hA000_0000 + 32'(n - 4) : 32'd0;
      checks++;
      if (flop_out !== want || out_valid !== (n >= 4) || clamped !== 1'b0) begin
        errors++;
        $display("FAIL delay5 edge=%0d got=%h/%b/%b want=%h/%b/0", n, flop_out, out_valid, clamped, want, (n >= 4));
      end
    end
  endtask

  task automatic test_clamping();
    logic [31:0] din;
    for (int i = 0; i < 6; i++) begin
      din = $urandom;
      step(1'b1, 32'd0, din);
      checks++;
      if (flop_out !== din || out_valid !== 1'b1 || clamped !== 1'b1) begin
        errors++;
        $display("FAIL clamp_zero edge=%0d got=%h/%b/%b want=%h/1/1", i, flop_out, out_valid, clamped, din);
      end
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 32'h0001_0010, $urandom);
      checks++;
      if (flop_out !== exp_out || out_valid !== exp_valid || clamped !== 1'b1) begin
        errors++;
        $display("FAIL clamp_big edge=%0d got=%h/%b/%b want=%h/%b/1", i, flop_out, out_valid, clamped, exp_out, exp_valid);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'd16, $urandom);
      checks++;
      if (flop_out !== exp_out || out_valid !== exp_valid || clamped !== 1'b0) begin
        errors++;
        $display("FAIL clamp_16 edge=%0d got=%h/%b/%b want=%h/%b/0", i, flop_out, out_valid, clamped, exp_out, exp_valid);
      end
    end
  endtask

  task automatic test_delay_change();
    logic [31:0] sent[$];
    logic [31:0] din;
    int e;
    step(1'b0, 32'd3, 32'd0);
    for (int i = 0; i < 20; i++) begin
      din = $urandom;
      sent.push_back(din);
      step(1'b1, 32'd3, din);
      checks++;
      if (flop_out !== exp_out || out_valid !== exp_valid) begin
        errors++;
        $display("FAIL d3_stream edge=%0d got=%h/%b want=%h/%b", i, flop_out, out_valid, exp_out, exp_valid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      din = $urandom;
      sent.push_back(din);
      e = sent.size() - 1;
      step(1'b1, 32'd8, din);
      checks++;
      if (flop_out !== sent[e - 7] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL d8_switch edge=%0d got=%h/%b want=%h/1", e, flop_out, out_valid, sent[e - 7]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      din = $urandom;
      sent.push_back(din);
      e = sent.size() - 1;
      step(1'b1, 32'd2, din);
      checks++;
      if (flop_out !== sent[e - 1] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL d2_switch edge=%0d got=%h/%b want=%h/1", e, flop_out, out_valid, sent[e - 1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] want;
    step(1'b0, 32'd6, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'd6, 32'hB000_0000 + 32'(i));
    end
    step(1'b0, 32'd6, 32'hB000_00FF);
    checks++;
    if (flop_out !== 32'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got=%h/%b want=0/0", flop_out, out_valid);
    end
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 32'd6, 32'hC000_0000 + 32'(j));
      want = (j >= 5) ? 32'hC000_0000 + 32'(j - 5) : 32'd0;
      checks++;
      if (flop_out !== want || out_valid !== (j >= 5)) begin
        errors++;
        $display("FAIL post_reset edge=%0d got=%h/%b want=%h/%b", j, flop_out, out_valid, want, (j >= 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 32'd16, 32'd0);
    for (int j = 0; j < 100; j++) begin
      step(1'b1, 32'd16, $urandom);
      checks++;
      if (flop_out !== exp_out || out_valid !== (j >= 15) || clamped !== 1'b0) begin
        errors++;
        $display("FAIL max_delay edge=%0d got=%h/%b/%b want=%h/%b/0", j, flop_out, out_valid, clamped, exp_out, (j >= 15));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] nc;
    logic        rn;
    for (int j = 0; j < 300; j++) begin
      rn = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 9))
        0:       nc = $urandom;
        1:       nc = 32'd0;
        default: nc = 32'($urandom_range(1, 18));
      endcase
      step(rn, nc, $urandom);
      checks++;
      if (flop_out !== exp_out || out_valid !== exp_valid || clamped !== exp_clamped) begin
        errors++;
        $display("FAIL random edge=%0d nc=%0d got=%h/%b/%b want=%h/%b/%b", j, nc, flop_out, out_valid, clamped, exp_out, exp_valid, exp_clamped);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    num_clks = 32'd0;
    flop_in  = 32'd0;
    test_reset();
    test_pass_through();
    test_delay5_wrap();
    test_clamping();
    test_delay_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flop_delay_line.md
Name: flop_delay_line

Overview:
- Programmable-latency flop pipeline; the responder end of the floptest bench interface (clk, num_clks, flop_in, flop_out).
- Captures flop_in every clock and returns it on flop_out exactly d clocks later.
- d is taken from num_clks and clamped to [1, MAX_DELAY].
- Adds out_valid and clamped status so the bench checks only meaningful samples.

Parameters:
- DATA_WIDTH, 32, width of flop_in/flop_out.
- MAX_DELAY, 16, maximum supported delay in clocks (>=2); history depth.
- PTR_WIDTH, 4, pointer width; must satisfy 2**PTR_WIDTH >= MAX_DELAY.

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- num_clks  input  32  requested delay in clocks, unsigned; sampled every edge.
- flop_in  input  DATA_WIDTH  data captured every rising edge while reset_n=1.
- flop_out  output  DATA_WIDTH  delayed data, registered.
- out_valid  output  1  flop_out holds a genuinely captured sample for the current d, registered.
- clamped  output  1  num_clks was 0 or >MAX_DELAY at the last edge, registered.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous, active-low.
  - An edge with reset_n=0 sets flop_out=0, out_valid=0, clamped=0, fill count=0, write pointer=0, and every history entry to 0.
  - No sample is captured on a reset edge.
  - Reset asserted mid-stream discards all history; behaviour afterwards is identical to power-on.
- Effective delay d, computed each edge from num_clks:
  - d=1 if num_clks==0.
  - d=MAX_DELAY if num_clks>MAX_DELAY; all 32 bits are compared, no truncation.
  - d=num_clks otherwise.
  - clamped<=1 in the two clamp cases, else 0.
- Latency:
  - A sample captured at edge k appears on flop_out immediately after edge k+d-1.
  - d=1 behaves as a single D flop.
  - Formally, flop_out after edge k = flop_in sampled at edge k-(d-1).
- Storage:
  - Circular buffer of MAX_DELAY-1 entries plus the output register.
  - Write pointer increments modulo MAX_DELAY-1 on every non-reset edge.
  - Read tap = write pointer minus (d-1), modulo depth. Wrap-around must be seamless.
- Fill count:
  - Counts non-reset edges since reset; saturates at MAX_DELAY and never wraps.
  - out_valid after edge k = (fill count after edge k >= d).
  - Before valid, flop_out carries the reset zeros from history.
- num_clks change mid-stream:
  - History is not flushed; the new d takes effect at the same edge.
  - Increasing d: output jumps back to older history. out_valid drops if the fill count < new d.
  - Decreasing d: intermediate samples are skipped. out_valid stays 1 if it was 1.
- Simultaneous events:
  - reset_n=0 overrides everything.
  - A num_clks change and a pointer wrap on the same edge need no special case.
- Structure: no combinational path from any input to any output.
- Synthesizable; no initial blocks; memory reset by explicit loop.

Test Plan:
1. Reset then pass-through:
   - Stimulus: reset_n=0 for 2 edges, then num_clks=1, flop_in=edge index (1,2,3...).
   - Response: flop_out equals the value applied at the same edge; out_valid=1 from the first post-reset edge; clamped=0.
2. Delay 5 with wrap:
   - Stimulus: num_clks=5, flop_in=32'hA000_0000+n for 40 edges.
   - Response: flop_out at edge n = A000_0000+(n-4); out_valid low for edges 0-3, high from edge 4; no glitch at pointer wrap (edges 15/16/30/31).
3. Clamping:
   - Stimulus: num_clks=0, then 32'h0001_0010 (>MAX_DELAY), then 16.
   - Response: num_clks=0 behaves as d=1 with clamped=1; 32'h0001_0010 behaves as d=16 with clamped=1; 16 behaves as d=16 with clamped=0.
4. Delay change mid-stream:
   - Stimulus: run at d=3 for 20 edges, then num_clks=8.
   - Response: on the same edge flop_out = sample from 7 edges earlier; out_valid stays 1 (fill=16).
   - Stimulus: switch back to 2.
   - Response: output = sample from 1 edge earlier.
5. Reset mid-operation:
   - Stimulus: d=6 streaming; reset_n=0 for 1 edge at edge 10; streaming resumes.
   - Response: flop_out=0 and out_valid=0 after the reset edge; the first post-reset sample appears 6 edges later, with no pre-reset data ever observed.
6. Max delay back-to-back:
   - Stimulus: num_clks=16, random data for 100 edges.
   - Response: scoreboard matches every sample with a 16-edge offset; out_valid rises exactly at edge 15 after reset.
